// File: rtl/xvec_vscale_src_b_stage_pkg.sv
// Shared encodings for the xvec operand-B select stage: source select codes and
// skid-buffer occupancy states.
package xvec_vscale_src_b_stage_pkg;

  localparam int unsigned SRC_B_SEL_WIDTH = 2;

  typedef enum logic [SRC_B_SEL_WIDTH-1:0] {
    SRC_B_RS2   = 2'd0,
    SRC_B_IMM   = 2'd1,
    SRC_B_FOUR  = 2'd2,
    SRC_B_SPLAT = 2'd3
  } src_b_sel_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/xvec_src_b_lane_mux.sv
// Per-lane operand-B select: rs2 lane, immediate, constant four or lane-0 splat,
// forced to zero when the lane is disabled.
module xvec_src_b_lane_mux
  import xvec_vscale_src_b_stage_pkg::*;
#(
  parameter int unsigned XPR_LEN   = 32,
  parameter int unsigned SEL_WIDTH = SRC_B_SEL_WIDTH
) (
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic [XPR_LEN-1:0]   imm,
  input  logic [XPR_LEN-1:0]   lane_data,
  input  logic [XPR_LEN-1:0]   lane0_data,
  input  logic                 en,
  output logic [XPR_LEN-1:0]   result
);

  localparam logic [XPR_LEN-1:0] FOUR_VAL = XPR_LEN'(4);

  always_comb begin
    result = '0;
    if (en) begin
      case (sel)
        SRC_B_RS2:   result = lane_data;
        SRC_B_IMM:   result = imm;
        SRC_B_FOUR:  result = FOUR_VAL;
        SRC_B_SPLAT: result = lane0_data;
        default:     result = '0;
      endcase
    end
  end

endmodule

// File: rtl/xvec_vscale_src_b_stage.sv
// Registered operand-B select stage: per-lane select and mask feeding a 2-entry
// skid buffer with registered valid/ready on both sides.
module xvec_vscale_src_b_stage
  import xvec_vscale_src_b_stage_pkg::*;
#(
  parameter int unsigned XPR_LEN   = 32,
  parameter int unsigned LANES     = 2,
  parameter int unsigned SEL_WIDTH = SRC_B_SEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_WIDTH-1:0]       src_b_sel,
  input  logic [XPR_LEN-1:0]         imm,
  input  logic [LANES*XPR_LEN-1:0]   rs2_data,
  input  logic [LANES-1:0]           lane_en,
  input  logic                       kill,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*XPR_LEN-1:0]   alu_src_b
);

  localparam int unsigned VEC_W = LANES * XPR_LEN;

  logic [VEC_W-1:0] lane_res;
  logic [VEC_W-1:0] head_q;
  logic [VEC_W-1:0] tail_q;
  skid_state_e      state_q;
  skid_state_e      state_d;
  logic             push;
  logic             pop;
  logic             head_load_new;
  logic             head_load_tail;
  logic             tail_load_new;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    xvec_src_b_lane_mux #(
      .XPR_LEN  (XPR_LEN),
      .SEL_WIDTH(SEL_WIDTH)
    ) u_lane_mux (
      .sel       (src_b_sel),
      .imm       (imm),
      .lane_data (rs2_data[g*XPR_LEN +: XPR_LEN]),
      .lane0_data(rs2_data[0 +: XPR_LEN]),
      .en        (lane_en[g]),
      .result    (lane_res[g*XPR_LEN +: XPR_LEN])
    );
  end

  // Both handshakes are decodes of the state register, so no ready path is combinational.
  assign in_ready  = (state_q != SKID_TWO);
  assign out_valid = (state_q != SKID_EMPTY);
  assign alu_src_b = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    head_load_new  = 1'b0;
    head_load_tail = 1'b0;
    tail_load_new  = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d       = SKID_ONE;
          head_load_new = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_load_new = 1'b1;
        end else if (push) begin
          state_d       = SKID_TWO;
          tail_load_new = 1'b1;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          state_d        = SKID_ONE;
          head_load_tail = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Kill drops everything, including a push arriving in the same cycle.
    if (kill) begin
      state_d        = SKID_EMPTY;
      head_load_new  = 1'b0;
      head_load_tail = 1'b0;
      tail_load_new  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      if (head_load_new) begin
        head_q <= lane_res;
      end else if (head_load_tail) begin
        head_q <= tail_q;
      end
      if (tail_load_new) begin
        tail_q <= lane_res;
      end
    end
  end

endmodule

// File: tb/tb_xvec_vscale_src_b_stage.sv
// Directed bench for xvec_vscale_src_b_stage with hand-computed expected values.
module tb_xvec_vscale_src_b_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  src_b_sel;
  logic [31:0] imm;
  logic [63:0] rs2_data;
  logic [1:0]  lane_en;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_src_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [1:0] S_RS2 = 2'd0;
  localparam logic [1:0] S_IMM = 2'd1;
  localparam logic [1:0] S_FOUR = 2'd2;
  localparam logic [1:0] S_SPLAT = 2'd3;

  xvec_vscale_src_b_stage #(
    .XPR_LEN  (32),
    .LANES    (2),
    .SEL_WIDTH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src_b_sel(src_b_sel),
    .imm      (imm),
    .rs2_data (rs2_data),
    .lane_en  (lane_en),
    .kill     (kill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_src_b(alu_src_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    kill      = 1'b0;
    src_b_sel = S_IMM;
    imm       = 32'h1234_5678;
    rs2_data  = 64'hDEAD_BEEF_CAFE_F00D;
    lane_en   = 2'b11;

    // Reset held two cycles with in_valid high
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu_src_b", alu_src_b, 64'd0);
    reset = 1'b0;

    // Select modes, streaming with out_ready=1
    out_ready = 1'b1;
    rs2_data  = 64'h0000_0002_FFFF_FFFE;
    imm       = 32'hFFFF_FFF0;
    src_b_sel = S_RS2;
    tick();
    chk("mode_rs2_valid", 64'(out_valid), 64'd1);
    chk("mode_rs2", alu_src_b, 64'h0000_0002_FFFF_FFFE);
    src_b_sel = S_IMM;
    tick();
    chk("mode_imm", alu_src_b, 64'hFFFF_FFF0_FFFF_FFF0);
    src_b_sel = S_FOUR;
    tick();
    chk("mode_four", alu_src_b, 64'h0000_0004_0000_0004);
    src_b_sel = S_SPLAT;
    tick();
    chk("mode_splat", alu_src_b, 64'hFFFF_FFFE_FFFF_FFFE);

    // Lane mask
    src_b_sel = S_IMM;
    imm       = 32'h5;
    lane_en   = 2'b01;
    tick();
    chk("mask_lo", alu_src_b, 64'h0000_0000_0000_0005);
    src_b_sel = S_RS2;
    lane_en   = 2'b10;
    tick();
    chk("mask_hi", alu_src_b, 64'h0000_0002_0000_0000);
    lane_en  = 2'b11;
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Backpressure: A, B, C with out_ready low
    out_ready = 1'b0;
    src_b_sel = S_RS2;
    in_valid  = 1'b1;
    rs2_data  = 64'h1111_1111_AAAA_AAAA;
    tick();
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    chk("bp_a_head", alu_src_b, 64'h1111_1111_AAAA_AAAA);
    rs2_data = 64'h2222_2222_BBBB_BBBB;
    tick();
    chk("bp_b_ready", 64'(in_ready), 64'd0);
    chk("bp_b_head", alu_src_b, 64'h1111_1111_AAAA_AAAA);
    rs2_data = 64'h3333_3333_CCCC_CCCC;
    tick();
    chk("bp_c_held_ready", 64'(in_ready), 64'd0);
    chk("bp_stable", alu_src_b, 64'h1111_1111_AAAA_AAAA);
    chk("bp_stable_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", alu_src_b, 64'h2222_2222_BBBB_BBBB);
    chk("bp_out_b_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_out_c", alu_src_b, 64'h3333_3333_CCCC_CCCC);
    chk("bp_out_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Full throughput: eight back-to-back pushes
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rs2_data = {32'(i + 16), 32'(i * 3 + 1)};
      tick();
      chk("tp_valid", 64'(out_valid), 64'd1);
      chk("tp_ready", 64'(in_ready), 64'd1);
      chk("tp_data", alu_src_b, {32'(i + 16), 32'(i * 3 + 1)});
    end
    in_valid = 1'b0;
    tick();
    chk("tp_drain", 64'(out_valid), 64'd0);

    // Kill with a full buffer and a pending push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rs2_data  = 64'h4444_4444_0000_0001;
    tick();
    rs2_data = 64'h5555_5555_0000_0002;
    tick();
    chk("kill_full", 64'(in_ready), 64'd0);
    rs2_data = 64'h6666_6666_0000_0003;
    kill     = 1'b1;
    tick();
    chk("kill2_valid", 64'(out_valid), 64'd0);
    chk("kill2_ready", 64'(in_ready), 64'd1);

    // Kill with one entry and a real same-cycle push
    kill     = 1'b0;
    rs2_data = 64'h7777_7777_0000_0004;
    tick();
    chk("kill1_pre", alu_src_b, 64'h7777_7777_0000_0004);
    rs2_data = 64'h8888_8888_0000_0005;
    kill     = 1'b1;
    tick();
    chk("kill1_valid", 64'(out_valid), 64'd0);
    chk("kill1_ready", 64'(in_ready), 64'd1);
    kill      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("kill_dropped", 64'(out_valid), 64'd0);

    // Reset mid-transfer discards buffered entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rs2_data  = 64'h9999_9999_0000_0006;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", alu_src_b, 64'd0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
